// File: rtl/i2_router_out_sched.sv
// Router output scheduler: picks priority or regular FIFO per packet, holds the output
// until the tail flit, forces one regular packet after STARVE_LIMIT priority grants.
module i2_router_out_sched #(
  parameter int         STARVE_LIMIT = 4,
  parameter logic [2:0] HEAD_PRI     = 3'b001,
  parameter logic [2:0] HEAD_REG     = 3'b000,
  parameter logic [2:0] CODE_TAIL    = 3'b011
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pri_empty,
  input  logic       reg_empty,
  input  logic [2:0] pri_head,
  input  logic [2:0] reg_head,
  input  logic       output_bussy,
  output logic       output_req,
  output logic       pri_read,
  output logic       reg_read,
  output logic       FIFOsel,
  output logic       proto_err
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] SEND_PRI = 2'b01;
  localparam logic [1:0] SEND_REG = 2'b10;

  logic [1:0]    state;
  logic [CW-1:0] starve_cnt;

  logic in_idle, pri_elig, reg_elig, force_reg, grant_pri, grant_reg;
  logic pri_bad, reg_bad, drop_pri, drop_reg;
  logic req_raw, xfer, tail_done;
  logic [2:0] active_head;

  assign in_idle   = (state == IDLE);
  assign pri_elig  = !pri_empty && (pri_head == HEAD_PRI);
  assign reg_elig  = !reg_empty && (reg_head == HEAD_REG);
  assign force_reg = (starve_cnt == LIMIT) && reg_elig;
  assign grant_reg = in_idle && reg_elig && (force_reg || !pri_elig);
  assign grant_pri = in_idle && pri_elig && !force_reg;

  // A stray non-head flit at an idle FIFO front is flushed one flit per cycle,
  // priority side first, only when nothing is being granted.
  assign pri_bad  = !pri_empty && (pri_head != HEAD_PRI);
  assign reg_bad  = !reg_empty && (reg_head != HEAD_REG);
  assign drop_pri = in_idle && !grant_pri && !grant_reg && pri_bad;
  assign drop_reg = in_idle && !grant_pri && !grant_reg && reg_bad && !pri_bad;

  assign req_raw     = ((state == SEND_PRI) && !pri_empty) || ((state == SEND_REG) && !reg_empty);
  assign xfer        = req_raw && !output_bussy;
  assign active_head = (state == SEND_PRI) ? pri_head : reg_head;
  assign tail_done   = xfer && (active_head == CODE_TAIL);

  // Combinational outputs are gated so they drop the moment reset rises.
  assign output_req = !reset && req_raw;
  assign pri_read   = !reset && (((state == SEND_PRI) && xfer) || drop_pri);
  assign reg_read   = !reset && (((state == SEND_REG) && xfer) || drop_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      FIFOsel    <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_pri) begin
            state   <= SEND_PRI;
            FIFOsel <= 1'b1;
            if (!reg_elig)
              starve_cnt <= '0;
            else if (starve_cnt != LIMIT)
              starve_cnt <= starve_cnt + CW'(1);
          end else if (grant_reg) begin
            state      <= SEND_REG;
            FIFOsel    <= 1'b0;
            starve_cnt <= '0;
          end
          if (drop_pri || drop_reg)
            proto_err <= 1'b1;
        end
        SEND_PRI, SEND_REG: begin
          if (tail_done)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2_router_out_sched.sv
// Directed bench for i2_router_out_sched: FIFO models feed the DUT, a negedge monitor
// pops an expected-read scoreboard on every read pulse.
module tb_i2_router_out_sched;

  logic       clk;
  logic       reset;
  logic       pri_empty, reg_empty, output_bussy;
  logic [2:0] pri_head, reg_head;
  logic       output_req, pri_read, reg_read, FIFOsel, proto_err;

  localparam logic [2:0] HP = 3'b001;
  localparam logic [2:0] HR = 3'b000;
  localparam logic [2:0] TL = 3'b011;
  localparam logic [2:0] BD = 3'b010;

  // Scoreboard entry: {kind[1:0], sel, flit}; kind 0 = transfer, 1 = discard, 2 = read while busy
  logic [15:0] pq[$];
  logic [15:0] rq[$];
  logic [18:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        pop_p = 1'b0;
  logic        pop_r = 1'b0;

  i2_router_out_sched dut (
    .clk          (clk),
    .reset        (reset),
    .pri_empty    (pri_empty),
    .reg_empty    (reg_empty),
    .pri_head     (pri_head),
    .reg_head     (reg_head),
    .output_bussy (output_bussy),
    .output_req   (output_req),
    .pri_read     (pri_read),
    .reg_read     (reg_read),
    .FIFOsel      (FIFOsel),
    .proto_err    (proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] fl(input logic [2:0] code, input int id);
    logic [31:0] v;
    v = id;
    return {code, v[12:0]};
  endfunction

  task automatic upd();
    logic [15:0] f;
    pri_empty = (pq.size() == 0);
    reg_empty = (rq.size() == 0);
    f = (pq.size() != 0) ? pq[0] : 16'h0;
    pri_head = f[15:13];
    f = (rq.size() != 0) ? rq[0] : 16'h0;
    reg_head = f[15:13];
  endtask

  // One clock: apply the pops the monitor saw, refresh FIFO fronts; returns at posedge+2.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (pop_p && pq.size() != 0) pq.delete(0);
    if (pop_r && rq.size() != 0) rq.delete(0);
    upd();
    #1;
  endtask

  task automatic push_pkt(input bit pri, input logic [2:0] code, input int id);
    if (pri) pq.push_back(fl(code, id));
    else     rq.push_back(fl(code, id));
  endtask

  task automatic expect_rd(input logic [1:0] kind, input bit sel, input logic [2:0] code, input int id);
    exp_q.push_back({kind, sel, fl(code, id)});
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || pq.size() != 0 || rq.size() != 0) && n < max) begin
      cyc();
      n++;
    end
    chk("drain_done", exp_q.size() + pq.size() + rq.size(), 0);
  endtask

  // Monitor
  initial begin
    logic [18:0] act;
    logic [18:0] e;
    forever begin
      @(negedge clk);
      pop_p = 1'b0;
      pop_r = 1'b0;
      chk("read_excl", {31'b0, pri_read & reg_read}, 0);
      if (pri_read || reg_read) begin
        act[18:17] = (output_req && !output_bussy) ? 2'd0 : (output_req ? 2'd2 : 2'd1);
        act[16]    = pri_read;
        if (pri_read) act[15:0] = (pq.size() != 0) ? pq[0] : 16'hxxxx;
        else          act[15:0] = (rq.size() != 0) ? rq[0] : 16'hxxxx;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual=%0h required=none", act);
        end else begin
          e = exp_q.pop_front();
          chk("sb_entry", {13'b0, act}, {13'b0, e});
        end
        if (output_req) chk("sb_fifosel", {31'b0, FIFOsel}, {31'b0, pri_read});
        pop_p = pri_read;
        pop_r = reg_read;
      end else if (output_req && !output_bussy) begin
        checks++;
        errors++;
        $display("FAIL xfer_no_read actual=req1_noread required=read");
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    output_bussy = 1'b0;
    upd();
    #1 reset = 1'b1;
    #1;
    chk("rst_req",   output_req, 0);
    chk("rst_pread", pri_read,   0);
    chk("rst_rread", reg_read,   0);
    chk("rst_sel",   FIFOsel,    0);
    chk("rst_perr",  proto_err,  0);
    repeat (2) cyc();
    reset = 1'b0;

    // Priority 3-flit packet: arbitration cycle, 3 transfers, then idle with FIFOsel held
    cyc();
    push_pkt(1, HP, 1); push_pkt(1, BD, 1); push_pkt(1, TL, 1); upd();
    expect_rd(0, 1, HP, 1); expect_rd(0, 1, BD, 1); expect_rd(0, 1, TL, 1);
    #1 chk("s34_arb_req", output_req, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      chk("s34_req", output_req, 1);
      chk("s34_pread", pri_read, 1);
      chk("s34_sel", FIFOsel, 1);
    end
    cyc();
    #1;
    chk("s34_idle_req", output_req, 0);
    chk("s34_sel_hold", FIFOsel, 1);
    drain(20);

    // Busy for 5 cycles mid-packet
    cyc();
    push_pkt(1, HP, 2); push_pkt(1, BD, 2); push_pkt(1, TL, 2); upd();
    expect_rd(0, 1, HP, 2); expect_rd(0, 1, BD, 2); expect_rd(0, 1, TL, 2);
    cyc();
    #1 chk("s36_first", pri_read, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      output_bussy = 1'b1;
      #1;
      chk("s36_busy_req", output_req, 1);
      chk("s36_busy_pread", pri_read, 0);
      chk("s36_busy_sel", FIFOsel, 1);
    end
    cyc();
    output_bussy = 1'b0;
    #1;
    chk("s36_resume_pread", pri_read, 1);
    chk("s36_resume_req", output_req, 1);
    drain(20);

    // Regular FIFO runs dry mid-packet while a priority head waits
    cyc();
    push_pkt(0, HR, 3); push_pkt(0, BD, 3); upd();
    expect_rd(0, 0, HR, 3); expect_rd(0, 0, BD, 3);
    cyc();
    #1 chk("s37_head", reg_read, 1);
    cyc();
    #1 chk("s37_body", reg_read, 1);
    cyc();
    push_pkt(1, HP, 4); push_pkt(1, TL, 4); upd();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("s37_stall_req", output_req, 0);
      chk("s37_stall_pread", pri_read, 0);
      chk("s37_stall_sel", FIFOsel, 0);
      cyc();
    end
    push_pkt(0, TL, 3); upd();
    expect_rd(0, 0, TL, 3); expect_rd(0, 1, HP, 4); expect_rd(0, 1, TL, 4);
    #1;
    chk("s37_tail_rread", reg_read, 1);
    chk("s37_tail_req", output_req, 1);
    drain(20);

    // Starvation guard: P P P P R P P P P R with both FIFOs loaded
    cyc();
    for (int k = 0; k < 8; k++) begin
      push_pkt(1, HP, 100 + k); push_pkt(1, TL, 100 + k);
    end
    for (int k = 0; k < 2; k++) begin
      push_pkt(0, HR, 200 + k); push_pkt(0, TL, 200 + k);
    end
    upd();
    begin
      int pi = 0;
      int ri = 0;
      for (int g = 0; g < 10; g++) begin
        if ((g % 5) == 4) begin
          expect_rd(0, 0, HR, 200 + ri); expect_rd(0, 0, TL, 200 + ri); ri++;
        end else begin
          expect_rd(0, 1, HP, 100 + pi); expect_rd(0, 1, TL, 100 + pi); pi++;
        end
      end
    end
    drain(200);

    // Stray body flit at the regular front while idle
    cyc();
    push_pkt(0, BD, 7); upd();
    expect_rd(1, 0, BD, 7);
    #1;
    chk("s38_drop_rread", reg_read, 1);
    chk("s38_drop_req", output_req, 0);
    chk("s38_perr_before", proto_err, 0);
    cyc();
    #1;
    chk("s38_perr", proto_err, 1);
    chk("s38_no_more_read", reg_read, 0);
    repeat (3) cyc();
    #1 chk("s38_sticky", proto_err, 1);

    // Reset in the middle of a priority packet
    cyc();
    push_pkt(1, HP, 8); push_pkt(1, BD, 8); push_pkt(1, TL, 8); upd();
    expect_rd(0, 1, HP, 8);
    cyc();
    #1 chk("s39_head", pri_read, 1);
    cyc();
    reset = 1'b1;
    #1;
    chk("s39_rst_req", output_req, 0);
    chk("s39_rst_pread", pri_read, 0);
    chk("s39_rst_rread", reg_read, 0);
    chk("s39_rst_sel", FIFOsel, 0);
    chk("s39_rst_perr", proto_err, 0);
    pq.delete();
    push_pkt(0, HR, 9); push_pkt(0, TL, 9); upd();
    expect_rd(0, 0, HR, 9); expect_rd(0, 0, TL, 9);
    cyc();
    #1;
    chk("s39_hold_req", output_req, 0);
    chk("s39_hold_rread", reg_read, 0);
    cyc();
    reset = 1'b0;
    #1 chk("s39_arb_req", output_req, 0);
    cyc();
    #1;
    chk("s39_grant_rread", reg_read, 1);
    chk("s39_grant_sel", FIFOsel, 0);
    drain(20);

    cyc();
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2_router_out_sched.md
I2_ROUTER_OUT_SCHED -- requirements
Module: i2_router_out_sched

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive priority packets granted while a regular head waits before one regular packet is forced.
REQ-002 SHALL have parameter HEAD_PRI, default 3'b001, meaning the priority head-flit code in flit[15:13].
REQ-003 SHALL have parameter HEAD_REG, default 3'b000, meaning the regular head-flit code.
REQ-004 SHALL have parameter CODE_TAIL, default 3'b011, meaning the tail-flit code; any other non-head code is a body flit.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port pri_empty, input, 1 bit: priority FIFO empty.
REQ-008 SHALL have port reg_empty, input, 1 bit: regular FIFO empty.
REQ-009 SHALL have port pri_head, input, 3 bits: [15:13] of the priority FIFO front flit (first-word-fall-through).
REQ-010 SHALL have port reg_head, input, 3 bits: [15:13] of the regular FIFO front flit.
REQ-011 SHALL have port output_bussy, input, 1 bit: downstream cannot accept a flit this cycle.
REQ-012 SHALL have port output_req, output, 1 bit: a valid flit is presented on the router output.
REQ-013 SHALL have port pri_read, output, 1 bit: pop the priority FIFO.
REQ-014 SHALL have port reg_read, output, 1 bit: pop the regular FIFO.
REQ-015 SHALL have port FIFOsel, output, 1 bit: output mux select, 1 = priority FIFO, 0 = regular FIFO.
REQ-016 SHALL have port proto_err, output, 1 bit: sticky flag set when a non-head flit is found at a FIFO front while IDLE.

Function
REQ-017 SHALL implement an FSM with states IDLE, SEND_PRI and SEND_REG.
REQ-018 In IDLE, an eligible priority source SHALL be: pri_empty=0 and pri_head==HEAD_PRI.
REQ-019 In IDLE, an eligible regular source SHALL be: reg_empty=0 and reg_head==HEAD_REG.
REQ-020 IDLE arbitration, one cycle:
  - forced regular (starve_cnt==STARVE_LIMIT and regular eligible) -> SEND_REG;
  - else priority eligible -> SEND_PRI;
  - else regular eligible -> SEND_REG;
  - else stay IDLE.
REQ-021 output_req SHALL be combinational: (SEND_PRI and !pri_empty) or (SEND_REG and !reg_empty); it SHALL be 0 in IDLE.
REQ-022 A transfer SHALL occur in a cycle with output_req=1 and output_bussy=0; pri_read or reg_read for the active FIFO SHALL be asserted in exactly that cycle.
REQ-023 pri_read and reg_read SHALL never be asserted together.
REQ-024 FIFOsel SHALL be 1 in SEND_PRI, 0 in SEND_REG, and hold its last value in IDLE.
REQ-025 Packets SHALL be atomic: the FSM leaves SEND_x only on the edge after a transfer whose head code equals CODE_TAIL, then returns to IDLE.
REQ-026 Latency: first flit presented 1 cycle after arbitration; back-to-back packets incur exactly one idle cycle.
REQ-027 Active FIFO empty mid-packet: output_req=0, state held, no interleaving of the other FIFO.
REQ-028 output_bussy=1: output_req held, no pop, state held indefinitely.
REQ-029 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL increment, saturating at STARVE_LIMIT, on each SEND_PRI grant made while regular is eligible.
REQ-030 starve_cnt SHALL clear on any SEND_REG grant, and on a SEND_PRI grant made while regular is not eligible.
REQ-031 If a FIFO is non-empty in IDLE with a front flit that is not its head code, and no grant is made this cycle, it SHALL be discarded by a read pulse (output_req=0) and proto_err SHALL be set; the priority FIFO is discarded first if both qualify.
REQ-032 Reset asserted mid-packet SHALL abort the packet immediately; FIFO contents are not touched.

Reset
REQ-033 While reset=1: state=IDLE, starve_cnt=0, FIFOsel=0, proto_err=0, output_req=0, pri_read=0, reg_read=0, independent of clk.

Verification
REQ-034 Scenario: priority 3-flit packet (001, 010, 011), bussy=0 -> SEND_PRI 1 cycle later; req and pri_read high for 3 consecutive cycles; IDLE after the tail.
REQ-035 Scenario: both FIFOs continuously hold packets, STARVE_LIMIT=4 -> grant order P, P, P, P, R, P, P, P, P, R.
REQ-036 Scenario: bussy=1 for 5 cycles mid-packet -> req stays 1, no pops, FIFOsel stable; resumes on the first cycle with bussy=0.
REQ-037 Scenario: regular packet active, its FIFO empties after the body flit, priority head arrives -> req=0, no switch; completes the regular tail when it arrives.
REQ-038 Scenario: reg_head=3'b010 at the front while IDLE with priority empty -> one reg_read with req=0; proto_err=1 until reset.
REQ-039 Scenario: reset pulse in the middle of SEND_PRI -> all outputs 0 asynchronously; IDLE arbitration resumes on the first edge after reset deasserts.
